// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among functional-unit result FIFOs.
// Optional macro CDB_FIXED_PRIO_EN: lowest-index eligible requester always wins (no pointer).
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NUM_REQ*TAG_W-1:0]     tag_i,
    input  logic [NUM_REQ*XLEN-1:0]      value_i,
    input  logic                         flush_i,
    output logic                         cdb_valid_o,
    output logic [TAG_W-1:0]             cdb_tag_o,
    output logic [XLEN-1:0]              cdb_value_o,
    output logic [$clog2(NUM_REQ)-1:0]   cdb_src_o,
    output logic                         busy_o
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] last_gnt_r;
    logic [SRC_W-1:0]   sel_s;
    logic               found_s;
    logic               s1_valid_r;
    logic [SRC_W-1:0]   s1_src_r;

    // A FIFO read last cycle still shows stale non-empty, so it sits out one cycle.
    assign elig_s = req_i & ~last_gnt_r;

`ifdef CDB_FIXED_PRIO_EN

    // Fixed-priority search: scanning downwards leaves the lowest eligible index selected.
    always_comb begin
        sel_s   = '0;
        found_s = |elig_s;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel_s = elig_s[k] ? SRC_W'(k) : sel_s;
        end
    end

`else

    localparam logic [SRC_W:0] NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);

    logic [SRC_W-1:0] ptr_r;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        logic [SRC_W:0] s;
        s = {1'b0, v} + (SRC_W + 1)'(1);
        return (s >= NUM_REQ_W) ? SRC_W'(0) : s[SRC_W-1:0];
    endfunction

    // Round-robin search starting at ptr_r, wrapping past the top index.
    always_comb begin
        logic [SRC_W:0] idx_v;
        logic           hit_v;
        sel_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v   = {1'b0, ptr_r} + (SRC_W + 1)'(k);
            idx_v   = (idx_v >= NUM_REQ_W) ? (idx_v - NUM_REQ_W) : idx_v;
            hit_v   = !found_s && elig_s[idx_v[SRC_W-1:0]];
            sel_s   = hit_v ? idx_v[SRC_W-1:0] : sel_s;
            found_s = found_s | hit_v;
        end
    end

    // Pointer advances past the winner only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (|gnt_s) begin
            ptr_r <= wrap_inc(sel_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

`endif

    // Grant decode; flush and reset both suppress every read enable.
    always_comb begin
        gnt_s = '0;
        if (rst_n && !flush_i && found_s) begin
            gnt_s[sel_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign gnt_o = gnt_s;

    // Grant history and S1 stage (flush already forced gnt_s to zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= '0;
            s1_valid_r <= 1'b0;
            s1_src_r   <= '0;
        end else begin
            last_gnt_r <= gnt_s;
            s1_valid_r <= |gnt_s;
            s1_src_r   <= (|gnt_s) ? sel_s : s1_src_r;
        end
    end

    // S2: capture the popped entry, which the FIFO presents the cycle after rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_o <= 1'b0;
            cdb_tag_o   <= '0;
            cdb_value_o <= '0;
            cdb_src_o   <= '0;
        end else if (s1_valid_r && !flush_i) begin
            cdb_valid_o <= 1'b1;
            cdb_tag_o   <= tag_i[s1_src_r*TAG_W +: TAG_W];
            cdb_value_o <= value_i[s1_src_r*XLEN +: XLEN];
            cdb_src_o   <= s1_src_r;
        end else begin
            cdb_valid_o <= 1'b0;
        end
    end

    assign busy_o = s1_valid_r | cdb_valid_o;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model plus a scoreboard queue of broadcasts.
module tb_cdb_arbiter;

    localparam int N     = 4;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N-1:0]       gnt;
    logic [N*TAG_W-1:0] tag;
    logic [N*XLEN-1:0]  value;
    logic               flush;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_value;
    logic [1:0]         cdb_src;
    logic               busy;

    cdb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .tag_i(tag), .value_i(value),
        .flush_i(flush), .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_value_o(cdb_value),
        .cdb_src_o(cdb_src), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  tag;
        logic [31:0] value;
        int          due;
    } item_t;

    item_t       sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [1:0]  m_ptr;
    logic [3:0]  m_last;
    logic [4:0]  h_tag;
    logic [31:0] h_value;
    logic [1:0]  h_src;

    function automatic logic [4:0] tag_of(input int i);
        return 5'(i + 1);
    endfunction

    // Value changes every cycle so capture in the wrong cycle is visible.
    function automatic logic [31:0] val_of(input int i, input int c);
        return 32'hA000_0000 | (32'(c) << 4) | 32'(i);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            tag[i*TAG_W +: TAG_W] = tag_of(i);
            value[i*XLEN +: XLEN] = val_of(i, cyc);
        end
    endtask

    // One clock cycle: drive, predict, compare at negedge, update model.
    task automatic step(input logic [3:0] r, input logic f, output logic [3:0] seen);
        logic [3:0] elig;
        logic [3:0] eg;
        int         s;
        logic       hit;
        logic       ev;
        logic       eb;
        item_t      it;
        req = r;
        flush = f;
        drive_data();
        @(negedge clk);
        seen = gnt;
        eg = 4'b0000;
        s = 0;
        hit = 1'b0;
        elig = r & ~m_last;
        if (!f) begin
`ifdef CDB_FIXED_PRIO_EN
            for (int k = 0; k < N; k++) begin
                if (!hit && elig[k]) begin hit = 1'b1; s = k; end
            end
`else
            for (int k = 0; k < N; k++) begin
                if (!hit && elig[(m_ptr + k) % N]) begin hit = 1'b1; s = (m_ptr + k) % N; end
            end
`endif
            if (hit) eg[s] = 1'b1;
        end
        total++;
        if (gnt !== eg) begin
            bad++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
        end
        ev = (sbq.size() > 0) && (sbq[0].due == cyc);
        if (ev) begin
            it = sbq.pop_front();
            h_tag = it.tag;
            h_value = it.value;
            h_src = it.src;
        end
        total++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {ev, h_tag, h_value, h_src}) begin
            bad++;
            $display("FAIL cdb cyc=%0d got=%b/%h/%h/%0d exp=%b/%h/%h/%0d", cyc,
                     cdb_valid, cdb_tag, cdb_value, cdb_src, ev, h_tag, h_value, h_src);
        end
        eb = ev || ((sbq.size() > 0) && (sbq[0].due == cyc + 1));
        total++;
        if (busy !== eb) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
        end
        if (f && (sbq.size() > 0) && (sbq[0].due == cyc + 1)) sbq.delete(0);
        if (hit && !f) begin
            it.src = 2'(s);
            it.tag = tag_of(s);
            it.value = val_of(s, cyc + 1);
            it.due = cyc + 2;
            sbq.push_back(it);
            m_ptr = 2'((s + 1) % N);
        end
        m_last = eg;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        logic [3:0] g;
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, g);
    endtask

    task automatic do_reset(input int n);
        req = 4'b1111;
        flush = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            drive_data();
            @(negedge clk);
            total++;
            if (gnt !== 4'b0000) begin
                bad++;
                $display("FAIL reset_gnt cyc=%0d got=%b exp=0000", cyc, gnt);
            end
            total++;
            if ({cdb_valid, cdb_tag, cdb_value, cdb_src, busy} !== 41'd0) begin
                bad++;
                $display("FAIL reset_cdb cyc=%0d got=%b/%h/%h/%0d/%b exp=all zero", cyc,
                         cdb_valid, cdb_tag, cdb_value, cdb_src, busy);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        sbq.delete();
        m_ptr = 2'd0;
        m_last = 4'd0;
        h_tag = 5'd0;
        h_value = 32'd0;
        h_src = 2'd0;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        do_reset(3);
        step(4'b1111, 1'b0, g);
        total++;
        if (g !== 4'b0001) begin
            bad++;
            $display("FAIL first_grant got=%b exp=0001", g);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        logic [3:0] exp_seq[5];
        do_reset(1);
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int j = 0; j < 5; j++) begin
            step(4'b1111, 1'b0, g);
            total++;
            if (g !== exp_seq[j]) begin
                bad++;
                $display("FAIL rr_seq step=%0d got=%b exp=%b", j, g, exp_seq[j]);
            end
        end
        drain();
    endtask

    task automatic test_single();
        logic [3:0] g;
        logic       ev;
        for (int j = 0; j < 8; j++) begin
            step((j < 6) ? 4'b0100 : 4'b0000, 1'b0, g);
            ev = ((j + 1) == 2) || ((j + 1) == 4) || ((j + 1) == 6);
            total++;
            if ((cdb_valid !== ev) || (ev && (cdb_src !== 2'd2))) begin
                bad++;
                $display("FAIL single rel=%0d got=%b/%0d exp=%b/2", j + 1, cdb_valid, cdb_src, ev);
            end
        end
        drain();
    endtask

    task automatic test_wrap_skip();
        logic [3:0] g;
        logic [3:0] exp_seq[3];
        exp_seq = '{4'b0001, 4'b0100, 4'b0001};
        step(4'b0100, 1'b0, g);
        step(4'b0000, 1'b0, g);
        step(4'b0000, 1'b0, g);
        for (int j = 0; j < 3; j++) begin
            step(4'b0101, 1'b0, g);
            total++;
            if (g !== exp_seq[j]) begin
                bad++;
                $display("FAIL wrap step=%0d got=%b exp=%b", j, g, exp_seq[j]);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        logic [3:0] g;
        step(4'b0010, 1'b0, g);
        step(4'b0010, 1'b1, g);
        total++;
        if (g !== 4'b0000) begin
            bad++;
            $display("FAIL flush_gnt got=%b exp=0000", g);
        end
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill got=%b exp=0", cdb_valid);
        end
        step(4'b0010, 1'b0, g);
        for (int j = 0; j < 4; j++) step(4'b1111, 1'b0, g);
        step(4'b1111, 1'b1, g);
        for (int j = 0; j < 3; j++) step(4'b1111, 1'b0, g);
        drain();
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        for (int j = 0; j < 3; j++) step(4'b1111, 1'b0, g);
        do_reset(2);
        step(4'b1111, 1'b0, g);
        total++;
        if (g !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_grant got=%b exp=0001", g);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        for (int j = 0; j < 300; j++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0), g);
        end
        drain();
    endtask

    task automatic test_fixed_prio();
        logic [3:0] g;
        logic [3:0] exp_a[4];
        logic [3:0] exp_b[4];
        exp_a = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        exp_b = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        for (int j = 0; j < 4; j++) begin
            step(4'b0011, 1'b0, g);
            total++;
            if (g !== exp_a[j]) begin
                bad++;
                $display("FAIL fixed_a step=%0d got=%b exp=%b", j, g, exp_a[j]);
            end
        end
        drain();
        for (int j = 0; j < 4; j++) begin
            step(4'b1101, 1'b0, g);
            total++;
            if (g !== exp_b[j]) begin
                bad++;
                $display("FAIL fixed_b step=%0d got=%b exp=%b", j, g, exp_b[j]);
            end
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b1;
        req = 4'b0000;
        flush = 1'b0;
        tag = '0;
        value = '0;
        @(posedge clk);
        #1;
        test_reset();
`ifdef CDB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_wrap_skip();
`endif
        test_single();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the functional-unit result FIFOs (ALU, branch, load/store, mul/div) of the Tomasulo back end. Each cycle it grants at most one non-empty FIFO a read, captures the popped {tag, value} one cycle later, and broadcasts it on the registered CDB outputs to the reservation stations and ROB. It drives each FIFO's `rd_en`/`rd_cs` directly from its grant vector.

## Interface
- `NUM_REQ`, default 4: number of requesting result FIFOs (2..8).
- `XLEN`, default 32: result value width.
- `TAG_W`, default 5: ROB tag width.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  NUM_REQ  bit i = FIFO i not empty (`!fifo_empty`).
- `gnt_o`  out  NUM_REQ  one-hot-or-zero read enable to FIFO i; combinational in the request cycle.
- `tag_i`  in  NUM_REQ*TAG_W  FIFO i data_out tag, slice [i*TAG_W +: TAG_W].
- `value_i`  in  NUM_REQ*XLEN  FIFO i data_out value, slice [i*XLEN +: XLEN].
- `flush_i`  in  1  mispredict/exception flush; kills in-flight broadcasts.
- `cdb_valid_o`  out  1  CDB broadcast valid.
- `cdb_tag_o`  out  TAG_W  broadcast ROB tag.
- `cdb_value_o`  out  XLEN  broadcast value.
- `cdb_src_o`  out  $clog2(NUM_REQ)  index of source FIFO.
- `busy_o`  out  1  high while any grant is in flight (stage S1 valid or `cdb_valid_o`).

## Operation
- Pipeline: G (grant, combinational) -> S1 (registered: valid, src index) -> S2 (registered CDB outputs).
- Eligible set: `req_i & ~last_gnt`; `last_gnt` is the `gnt_o` registered from the previous cycle. A FIFO granted in cycle N is ineligible in N+1 because its empty flag lags the read by one cycle.
- Round-robin pointer `ptr` (0..NUM_REQ-1): search eligible bits starting at `ptr`, wrapping from NUM_REQ-1 to 0; grant the first hit.
- On grant to i: `ptr <= (i+1) mod NUM_REQ`; S1 <= {valid=1, src=i}.
- With no eligible bit: `gnt_o`=0, `ptr` unchanged, S1 valid <= 0.
- S1 valid: S2 <= {valid=1, tag_i[src], value_i[src], src}. The FIFO presents popped data in the cycle after `rd_en`. S1 invalid: `cdb_valid_o` <= 0, data outputs hold their previous value.
- The CDB has no backpressure: every broadcast is a single-cycle pulse per granted entry.
- Flush: while `flush_i`=1, `gnt_o`=0. S1 valid and S2 valid clear at the next edge, and `last_gnt` clears. `ptr` is unchanged. Entries already popped are discarded, and surviving FIFO entries are granted normally after the flush.
- Reset (async, `rst_n`=0): `ptr`=0, `last_gnt`=0, S1 valid=0, `cdb_valid_o`=0, `cdb_tag_o`=0, `cdb_value_o`=0, `cdb_src_o`=0. `gnt_o`=0 while in reset. Reset mid-operation drops all in-flight results.

## Timing
- Grant to broadcast: 2 cycles. `gnt_o[i]` in cycle N gives `cdb_valid_o` in N+2.
- Throughput: one broadcast per cycle when at least two FIFOs are non-empty. A single non-empty FIFO gets one broadcast every 2 cycles (mask rule).
- `gnt_o` depends combinationally on `req_i`, `flush_i`, `ptr`, `last_gnt` only. It has no path from `tag_i`/`value_i`.
- Same-cycle `flush_i` and request: flush wins, and no grant is issued.

## Configuration
- `CDB_FIXED_PRIO_EN` defined: the round-robin pointer is removed and the lowest-index eligible requester always wins. The `last_gnt` mask is kept; pipeline and latency are unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold `rst_n`=0 with `req_i`=4'b1111. Expect `gnt_o`=0 and all CDB outputs 0. After release, the first grant goes to FIFO 0 (`ptr`=0).
- Round robin: `req_i`=4'b1111 held, distinct tags 1..4. Expect `gnt_o` sequence 0001,0010,0100,1000,0001. `cdb_tag_o` follows 2 cycles later and `cdb_valid_o` stays high continuously.
- Single requester: only `req_i[2]`=1 for 6 cycles. Expect grants in cycles 0,2,4, broadcasts in cycles 2,4,6 with `cdb_src_o`=2.
- Wrap/skip: `ptr`=3 with `req_i`=4'b0101. Expect grant to 0, then 2, then 0.
- Flush: grant FIFO 1 in cycle N with `flush_i`=1 in N+1. Expect `cdb_valid_o`=0 in N+2, and `gnt_o`=0 during the flush cycle.
- Fixed priority (`CDB_FIXED_PRIO_EN`): `req_i`=4'b0011 held. Expect grants 0,1,0,1 (mask-driven alternation). With `req_i`=4'b1101, expect grants 0,2,0,2 and FIFO 3 is never granted.
